// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin arbiter that shares the single Uart write port
//            between NUM_REQ byte requesters. It presents one byte, holds it
//            until the Uart reports busy, acks the owner, then waits for the
//            frame to drain before it arbitrates again.
// Options  : UART_TX_ARB_LOCK_EN - packet lock (owner keeps the port until
//            it presents a byte flagged with req_last_i)
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int START_TIMEOUT = 64
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ack_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          error_o,
  output logic                          uart_write_o,
  output logic [DATA_WIDTH-1:0]         uart_data_o,
  input  logic                          uart_write_busy_i
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(START_TIMEOUT);
  localparam logic [IDX_W-1:0] C_LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [TMR_W-1:0] C_TMR_MAX  = TMR_W'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic [IDX_W-1:0]      r_last;
  logic [IDX_W-1:0]      w_last_nxt;
  logic [TMR_W-1:0]      r_timer;
  logic [TMR_W-1:0]      w_timer_nxt;
  logic                  w_write_nxt;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic [NUM_REQ-1:0]    w_grant_nxt;
  logic [NUM_REQ-1:0]    w_ack_nxt;
  logic                  w_error_nxt;

  // Arbitration result
  logic                  w_found;
  logic [IDX_W-1:0]      w_win;
  logic [IDX_W-1:0]      w_k;
  logic                  w_pick_valid;
  logic [IDX_W-1:0]      w_pick_idx;
  logic [DATA_WIDTH-1:0] w_pick_data;

`ifdef UART_TX_ARB_LOCK_EN
  logic r_lock;
  logic w_lock_nxt;
`else
  // Packet framing is not used when the lock is compiled out
  logic w_unused_last;
  assign w_unused_last = ^req_last_i;
`endif

  // Round-robin scan starting just after the last served requester, then lock override
  always_comb begin
    w_found      = 1'b0;
    w_win        = '0;
    w_k          = '0;
    w_pick_data  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_k = IDX_W'((int'(r_last) + off) % NUM_REQ);
      if (!w_found && req_i[w_k]) begin
        w_found = 1'b1;
        w_win   = w_k;
      end
    end
    w_pick_valid = w_found;
    w_pick_idx   = w_win;
`ifdef UART_TX_ARB_LOCK_EN
    // A locked owner that still requests is re-granted without arbitration
    if (r_lock && req_i[r_idx]) begin
      w_pick_valid = 1'b1;
      w_pick_idx   = r_idx;
    end
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_pick_idx == IDX_W'(k)) begin
        w_pick_data = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_last_nxt  = r_last;
    w_timer_nxt = r_timer;
    w_write_nxt = uart_write_o;
    w_data_nxt  = uart_data_o;
    w_grant_nxt = grant_o;
    w_ack_nxt   = '0;
    w_error_nxt = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
    w_lock_nxt  = r_lock;
`endif
    case (r_state)
      S_IDLE: begin
`ifdef UART_TX_ARB_LOCK_EN
        // Owner released its request mid-packet: drop the lock
        if (r_lock && !req_i[r_idx]) begin
          w_lock_nxt = 1'b0;
        end
`endif
        if (w_pick_valid) begin
          w_idx_nxt   = w_pick_idx;
          w_data_nxt  = w_pick_data;
          w_write_nxt = 1'b1;
          w_grant_nxt = NUM_REQ'(1) << w_pick_idx;
          w_timer_nxt = '0;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (uart_write_busy_i) begin
          w_write_nxt = 1'b0;
          w_ack_nxt   = NUM_REQ'(1) << r_idx;
`ifdef UART_TX_ARB_LOCK_EN
          w_lock_nxt  = ~req_last_i[r_idx];
`endif
          w_state_nxt = S_DRAIN;
        end else if (r_timer == C_TMR_MAX) begin
          // Uart never started: abort without ack, let the next scan pass over this owner
          w_write_nxt = 1'b0;
          w_error_nxt = 1'b1;
          w_last_nxt  = r_idx;
          w_grant_nxt = '0;
`ifdef UART_TX_ARB_LOCK_EN
          w_lock_nxt  = 1'b0;
`endif
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      S_DRAIN: begin
        if (!uart_write_busy_i) begin
          w_last_nxt  = r_idx;
          w_grant_nxt = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_idx        <= '0;
      r_last       <= C_LAST_RST;
      r_timer      <= '0;
      uart_write_o <= 1'b0;
      uart_data_o  <= '0;
      grant_o      <= '0;
      req_ack_o    <= '0;
      error_o      <= 1'b0;
    end else begin
      r_idx        <= w_idx_nxt;
      r_last       <= w_last_nxt;
      r_timer      <= w_timer_nxt;
      uart_write_o <= w_write_nxt;
      uart_data_o  <= w_data_nxt;
      grant_o      <= w_grant_nxt;
      req_ack_o    <= w_ack_nxt;
      error_o      <= w_error_nxt;
    end
  end

`ifdef UART_TX_ARB_LOCK_EN
  // Packet lock register
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_lock <= 1'b0;
    end else begin
      r_lock <= w_lock_nxt;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Scoreboard bench for uart_tx_arbiter with a simple Uart model
//            and per-requester byte queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int NUM_REQ       = 4;
  localparam int DATA_WIDTH    = 8;
  localparam int START_TIMEOUT = 64;

  logic                          clock_i = 1'b0;
  logic                          reset_i = 1'b1;
  logic [NUM_REQ-1:0]            req_i = '0;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i = '0;
  logic [NUM_REQ-1:0]            req_last_i = '0;
  logic [NUM_REQ-1:0]            req_ack_o;
  logic [NUM_REQ-1:0]            grant_o;
  logic                          error_o;
  logic                          uart_write_o;
  logic [DATA_WIDTH-1:0]         uart_data_o;
  logic                          uart_write_busy_i = 1'b0;

  uart_tx_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .DATA_WIDTH    (DATA_WIDTH),
    .START_TIMEOUT (START_TIMEOUT)
  ) dut (
    .clock_i           (clock_i),
    .reset_i           (reset_i),
    .req_i             (req_i),
    .req_data_i        (req_data_i),
    .req_last_i        (req_last_i),
    .req_ack_o         (req_ack_o),
    .grant_o           (grant_o),
    .error_o           (error_o),
    .uart_write_o      (uart_write_o),
    .uart_data_o       (uart_data_o),
    .uart_write_busy_i (uart_write_busy_i)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    int              idx;
    logic [7:0]      data;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Requester byte queues
  logic [7:0] rbuf [NUM_REQ][16];
  bit         rlst [NUM_REQ][16];
  int         rhd  [NUM_REQ];
  int         rtl  [NUM_REQ];

  // Uart model and monitors
  bit         uart_en     = 1'b1;
  int         busy_delay  = 1;
  int         busy_len    = 4;
  int         delay_left  = 0;
  int         busy_left   = 0;
  logic [7:0] cap_data    = '0;
  bit         ack_pending = 1'b0;
  int         ack_exp_idx = 0;
  bit         err_allowed = 1'b0;
  int         err_cnt     = 0;
  int         ack_cnt [NUM_REQ];
  int         cyc         = 0;
  int         rise_cyc    = 0;
  bit         prev_write  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_reqs();
    for (int k = 0; k < NUM_REQ; k++) begin
      req_i[k] = (rhd[k] != rtl[k]);
      req_data_i[k*DATA_WIDTH +: DATA_WIDTH] = rbuf[k][rhd[k] % 16];
      req_last_i[k] = rlst[k][rhd[k] % 16];
    end
  endtask

  task automatic push_req(input int k, input logic [7:0] d, input bit last);
    rbuf[k][rtl[k] % 16] = d;
    rlst[k][rtl[k] % 16] = last;
    rtl[k]++;
  endtask

  task automatic push_exp(input int k, input logic [7:0] d);
    exp_t e;
    e.idx  = k;
    e.data = d;
    sb.push_back(e);
  endtask

  // Clears bench state and resets the DUT for one clock edge
  task automatic start_test();
    @(negedge clock_i);
    reset_i = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      rhd[k] = 0;
      rtl[k] = 0;
      ack_cnt[k] = 0;
    end
    sb.delete();
    err_cnt     = 0;
    err_allowed = 1'b0;
    uart_en     = 1'b1;
    @(negedge clock_i);
    reset_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clock_i);
      done = (sb.size() == 0) && !uart_write_busy_i && !uart_write_o &&
             (grant_o == '0) && (delay_left == 0) && (busy_left == 0);
      for (int k = 0; k < NUM_REQ; k++) begin
        if (rhd[k] != rtl[k]) done = 1'b0;
      end
    end
    check_eq({tag, "_done"}, done, 1);
  endtask

  // Uart model, requester queues and output monitor, sampled just after each rising edge
  initial begin
    for (int k = 0; k < NUM_REQ; k++) begin
      rhd[k] = 0;
      rtl[k] = 0;
      ack_cnt[k] = 0;
    end
    forever begin
      @(posedge clock_i);
      #1;
      cyc++;
      if (uart_write_o && !prev_write) rise_cyc = cyc;
      prev_write = uart_write_o;
      if (reset_i) begin
        uart_write_busy_i = 1'b0;
        delay_left  = 0;
        busy_left   = 0;
        ack_pending = 1'b0;
      end else begin
        if (req_ack_o != '0) begin
          check_eq("ack_onehot", $countones(req_ack_o), 1);
          check_eq("ack_expected", ack_pending, 1);
          check_eq("ack_idx", req_ack_o, 1 << ack_exp_idx);
          check_eq("ack_vs_error", error_o, 0);
          ack_pending = 1'b0;
          for (int k = 0; k < NUM_REQ; k++) begin
            if (req_ack_o[k]) begin
              ack_cnt[k]++;
              if (rhd[k] != rtl[k]) rhd[k]++;
            end
          end
        end
        if (error_o) begin
          err_cnt++;
          check_eq("error_allowed", err_allowed, 1);
        end
        if (!uart_en) begin
          uart_write_busy_i = 1'b0;
        end else if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) uart_write_busy_i = 1'b0;
        end else if (delay_left > 0) begin
          check_eq("data_stable", uart_data_o, cap_data);
          check_eq("write_held", uart_write_o, 1);
          delay_left--;
          if (delay_left == 0) begin
            uart_write_busy_i = 1'b1;
            busy_left = busy_len;
          end
        end else if (uart_write_o) begin
          cap_data = uart_data_o;
          check_eq("sb_nonempty_on_write", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check_eq("uart_data", uart_data_o, e.data);
            check_eq("grant_at_write", grant_o, 1 << e.idx);
            ack_exp_idx = e.idx;
            ack_pending = 1'b1;
          end
          delay_left = busy_delay;
        end
      end
      drive_reqs();
    end
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;

    // ---- reset state
    start_test();
    @(negedge clock_i);
    check_eq("rst_write", uart_write_o, 0);
    check_eq("rst_data", uart_data_o, 0);
    check_eq("rst_grant", grant_o, 0);
    check_eq("rst_ack", req_ack_o, 0);
    check_eq("rst_error", error_o, 0);

    // ---- single byte from requester 1, busy two cycles after write
    busy_delay = 2;
    busy_len   = 4;
    push_exp(1, 8'hA5);
    push_req(1, 8'hA5, 1'b1);
    wait_done("t1", 100);
    check_eq("t1_ack1", ack_cnt[1], 1);
    check_eq("t1_ack_other", ack_cnt[0] + ack_cnt[2] + ack_cnt[3], 0);
    check_eq("t1_grant_idle", grant_o, 0);

    // ---- all four requesting, 10-cycle frames
    start_test();
    busy_delay = 1;
    busy_len   = 10;
    push_exp(0, 8'hA0);
    push_exp(1, 8'hA1);
    push_exp(2, 8'hA2);
    push_exp(3, 8'hA3);
    push_exp(0, 8'hA4);
    push_req(0, 8'hA0, 1'b1);
    push_req(0, 8'hA4, 1'b1);
    push_req(1, 8'hA1, 1'b1);
    push_req(2, 8'hA2, 1'b1);
    push_req(3, 8'hA3, 1'b1);
    wait_done("t2", 400);
    check_eq("t2_ack_total", ack_cnt[0] + ack_cnt[1] + ack_cnt[2] + ack_cnt[3], 5);
    check_eq("t2_ack0", ack_cnt[0], 2);

    // ---- start timeout: Uart never goes busy
    start_test();
    uart_en     = 1'b0;
    err_allowed = 1'b1;
    push_req(0, 8'h5A, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock_i);
      seen = error_o;
    end
    check_eq("t3_error_seen", seen, 1);
    check_eq("t3_error_latency", cyc - rise_cyc, START_TIMEOUT);
    check_eq("t3_write_dropped", uart_write_o, 0);
    check_eq("t3_no_ack", req_ack_o, 0);
    check_eq("t3_grant_idle", grant_o, 0);
    @(negedge clock_i);
    check_eq("t3_error_pulse", error_o, 0);
    check_eq("t3_reissue_write", uart_write_o, 1);
    check_eq("t3_reissue_grant", grant_o, 4'b0001);
    check_eq("t3_err_cnt", err_cnt, 1);
    check_eq("t3_ack_cnt", ack_cnt[0], 0);

    // ---- reset during DRAIN
    start_test();
    busy_delay = 1;
    busy_len   = 20;
    push_exp(0, 8'h40);
    push_req(0, 8'h40, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock_i);
      seen = req_ack_o[0];
    end
    check_eq("t4_ack_seen", seen, 1);
    reset_i = 1'b1;
    push_req(3, 8'h43, 1'b1);
    push_req(0, 8'h44, 1'b1);
    push_exp(0, 8'h44);
    push_exp(3, 8'h43);
    @(negedge clock_i);
    check_eq("t4_rst_write", uart_write_o, 0);
    check_eq("t4_rst_grant", grant_o, 0);
    check_eq("t4_rst_ack", req_ack_o, 0);
    check_eq("t4_rst_error", error_o, 0);
    check_eq("t4_rst_data", uart_data_o, 0);
    reset_i  = 1'b0;
    busy_len = 5;
    wait_done("t4", 200);

    // ---- packet from requester 2 with requester 0 competing
    start_test();
    busy_delay = 1;
    busy_len   = 6;
    push_req(2, 8'h11, 1'b0);
    push_req(2, 8'h22, 1'b0);
    push_req(2, 8'h33, 1'b1);
    push_exp(2, 8'h11);
`ifdef UART_TX_ARB_LOCK_EN
    push_exp(2, 8'h22);
    push_exp(2, 8'h33);
    push_exp(0, 8'h77);
`else
    push_exp(0, 8'h77);
    push_exp(2, 8'h22);
    push_exp(2, 8'h33);
`endif
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock_i);
      seen = uart_write_o;
    end
    check_eq("t5_first_write", seen, 1);
    push_req(0, 8'h77, 1'b1);
    wait_done("t5", 300);
    check_eq("t5_ack2", ack_cnt[2], 3);
    check_eq("t5_ack0", ack_cnt[0], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
